calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/stack word width.
REQ-002 SHALL have parameter COUNT_W, default 6, width of the stack occupancy count.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port key  input  5  numpad code; bit4=1 means a key is pressed, bits[3:2]=column, bits[1:0]=row.
REQ-006 SHALL have port top  input  WIDTH  current stack top.
REQ-007 SHALL have port next  input  WIDTH  entry below top.
REQ-008 SHALL have port count  input  COUNT_W  stack occupancy.
REQ-009 SHALL have port stack_error  input  1  overflow/underflow flag from the stack.
REQ-010 SHALL have ports push, pop, write  output  1 each  single-cycle stack strobes.
REQ-011 SHALL have port value  output  WIDTH  write data, valid when write=1.
REQ-012 SHALL have port busy  output  1  high while a multi-cycle operation runs.
REQ-013 SHALL have port error  output  1  sticky calculator error.

Function
REQ-014 SHALL use states IDLE, EXEC, MUL_RUN, MUL_DONE, WAIT_RELEASE.
REQ-015 In IDLE, key[4]=1 SHALL latch key, top, next and count, then go to EXEC; key[4]=0 SHALL leave the block in IDLE.
REQ-016 EXEC SHALL assert registered strobes for exactly one cycle, then go to WAIT_RELEASE (MUL_RUN for multiply).
REQ-017 Digit keys 0-9 (1=10000, 4=10001, 7=10010, 0=10011, 2=10100, 5=10101, 8=10110, 3=11000, 6=11001, 9=11010) SHALL write value=top*10+d, truncated mod 2^WIDTH; when count=0 they SHALL instead push value=d.
REQ-018 Key A (11100, enter) SHALL push.
REQ-019 Key B (11101, add) SHALL pop and write value=next+top, mod 2^WIDTH.
REQ-020 Key C (11110, subtract) SHALL pop and write value=next-top, mod 2^WIDTH.
REQ-021 Key D (11111, multiply) SHALL latch a=next and b=top, then run WIDTH cycles of shift-add in MUL_RUN; MUL_DONE SHALL pop and write the low WIDTH bits of the product.
REQ-022 Key E (11011, clear) SHALL write value=0 and SHALL clear error.
REQ-023 Key F (10111, drop) SHALL pop.
REQ-024 A binary op (B/C/D) with latched count<2, or F with count=0, SHALL issue no strobes and SHALL set error.
REQ-025 WAIT_RELEASE SHALL return to IDLE on the first cycle with key[4]=0, so a held key executes exactly once.
REQ-026 busy SHALL be 1 in EXEC, MUL_RUN and MUL_DONE, and 0 otherwise; key changes while busy SHALL be ignored.
REQ-027 error SHALL be set when stack_error=1 in any cycle, and SHALL stay set until key E or reset.
REQ-028 push, pop and write SHALL never all three be asserted in the same cycle; push SHALL never coincide with pop.

Reset
REQ-029 With reset_n=0, at the clock edge the block SHALL go to IDLE with push=pop=write=0, value=0, busy=0, error=0, and the multiply counter cleared.
REQ-030 Reset during MUL_RUN SHALL abort the multiply with no strobe issued.

Configuration
REQ-031 With macro CALC_SEQ_MUL_EN defined, key D SHALL multiply per REQ-021.
REQ-032 Without CALC_SEQ_MUL_EN, the MUL_RUN/MUL_DONE logic SHALL be absent and key D SHALL set error with no strobes.

Structure
REQ-033 Key-code constants and the state enum SHALL live in package calc_pkg.
REQ-034 The shift-add multiplier SHALL be sub-module calc_mul_iter (start/done handshake), instantiated only under CALC_SEQ_MUL_EN.

Verification
REQ-035 Bench SHALL check: count=0, press 7 then release -> one push with value=7; with top=7, press 2 -> one write with value=72.
REQ-036 Bench SHALL check: next=5, top=3, count=2, press C -> pop+write together in one cycle with value=2; with next=3, top=5 -> value=0xFFFFFFFE.
REQ-037 Bench SHALL check: next=1234, top=567, press D with macro defined -> busy high for WIDTH+2 cycles, then pop+write with value=699678.
REQ-038 Bench SHALL check: count=1, press B -> no strobes and error=1; then press E -> write with value=0 and error=0.
REQ-039 Bench SHALL check: key 1 held for 50 cycles -> exactly one write; reset_n=0 mid-multiply -> no strobes and all outputs return to reset values.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the calculator sequencer: FSM states, numpad key codes and key decode.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        EXEC         = 3'd1,
        MUL_RUN      = 3'd2,
        MUL_DONE     = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        OP_DIGIT = 3'd0,
        OP_ENTER = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_MUL   = 3'd4,
        OP_CLEAR = 3'd5,
        OP_DROP  = 3'd6,
        OP_NONE  = 3'd7
    } op_e;

    localparam logic [4:0] KEY_1 = 5'b10000;
    localparam logic [4:0] KEY_4 = 5'b10001;
    localparam logic [4:0] KEY_7 = 5'b10010;
    localparam logic [4:0] KEY_0 = 5'b10011;
    localparam logic [4:0] KEY_2 = 5'b10100;
    localparam logic [4:0] KEY_5 = 5'b10101;
    localparam logic [4:0] KEY_8 = 5'b10110;
    localparam logic [4:0] KEY_F = 5'b10111;
    localparam logic [4:0] KEY_3 = 5'b11000;
    localparam logic [4:0] KEY_6 = 5'b11001;
    localparam logic [4:0] KEY_9 = 5'b11010;
    localparam logic [4:0] KEY_E = 5'b11011;
    localparam logic [4:0] KEY_A = 5'b11100;
    localparam logic [4:0] KEY_B = 5'b11101;
    localparam logic [4:0] KEY_C = 5'b11110;
    localparam logic [4:0] KEY_D = 5'b11111;

    function automatic op_e key_op(input logic [4:0] code);
        op_e op;
        case (code)
            KEY_A:   op = OP_ENTER;
            KEY_B:   op = OP_ADD;
            KEY_C:   op = OP_SUB;
            KEY_D:   op = OP_MUL;
            KEY_E:   op = OP_CLEAR;
            KEY_F:   op = OP_DROP;
            KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
            KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: op = OP_DIGIT;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

    function automatic logic [3:0] key_digit(input logic [4:0] code);
        logic [3:0] d;
        case (code)
            KEY_1:   d = 4'd1;
            KEY_2:   d = 4'd2;
            KEY_3:   d = 4'd3;
            KEY_4:   d = 4'd4;
            KEY_5:   d = 4'd5;
            KEY_6:   d = 4'd6;
            KEY_7:   d = 4'd7;
            KEY_8:   d = 4'd8;
            KEY_9:   d = 4'd9;
            default: d = 4'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/calc_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per start.
// o_done is high during the final iteration cycle; o_product is valid the cycle after.
module calc_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    // Load operands on start, then accumulate one shifted multiplicand per cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a   <= {WIDTH{1'b0}};
            r_b   <= {WIDTH{1'b0}};
            r_acc <= {WIDTH{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_run <= 1'b0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= {WIDTH{1'b0}};
            r_cnt <= CNT_W'(WIDTH);
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_b[0]) begin
                r_acc <= r_acc + r_a;
            end
            r_a   <= r_a << 1'b1;
            r_b   <= r_b >> 1'b1;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_run <= 1'b0;
            end
        end
    end

    assign o_done    = r_run && (r_cnt == CNT_W'(1));
    assign o_product = r_acc;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: numpad-driven RPN calculator sequencer issuing single-cycle stack strobes.
// Key D multiplies only when CALC_SEQ_MUL_EN is defined; otherwise it flags an error.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 6
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [4:0]         key,
    input  logic [WIDTH-1:0]   top,
    input  logic [WIDTH-1:0]   next,
    input  logic [COUNT_W-1:0] count,
    input  logic               stack_error,
    output logic               push,
    output logic               pop,
    output logic               write,
    output logic [WIDTH-1:0]   value,
    output logic               busy,
    output logic               error
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [4:0]         r_key;
    logic [WIDTH-1:0]   r_top;
    logic [WIDTH-1:0]   r_next;
    logic [COUNT_W-1:0] r_count;
    logic               r_push;
    logic               r_pop;
    logic               r_write;
    logic [WIDTH-1:0]   r_value;
    logic               r_busy;
    logic               r_error;

    logic               w_push;
    logic               w_pop;
    logic               w_write;
    logic [WIDTH-1:0]   w_value;
    logic               w_set_err;
    logic               w_clr_err;
    op_e                w_op;
    logic [3:0]         w_digit;
    logic               w_count_zero;
    logic               w_count_lt2;

    assign w_op         = key_op(r_key);
    assign w_digit      = key_digit(r_key);
    assign w_count_zero = (r_count == {COUNT_W{1'b0}});
    assign w_count_lt2  = (r_count < COUNT_W'(2));

`ifdef CALC_SEQ_MUL_EN
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    calc_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_start   (w_mul_start),
        .i_a       (r_next),
        .i_b       (r_top),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
`endif

    // Next-state and strobe decode; strobes are registered so they appear the cycle after EXEC.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_write     = 1'b0;
        w_value     = r_value;
        w_set_err   = 1'b0;
        w_clr_err   = 1'b0;
`ifdef CALC_SEQ_MUL_EN
        w_mul_start = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (key[4]) begin
                    w_state_nxt = EXEC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EXEC: begin
                w_state_nxt = WAIT_RELEASE;
                case (w_op)
                    OP_DIGIT: begin
                        if (w_count_zero) begin
                            w_push  = 1'b1;
                            w_value = {{(WIDTH-4){1'b0}}, w_digit};
                        end else begin
                            w_write = 1'b1;
                            w_value = (r_top << 3'd3) + (r_top << 3'd1) + {{(WIDTH-4){1'b0}}, w_digit};
                        end
                    end
                    OP_ENTER: w_push = 1'b1;
                    OP_ADD, OP_SUB: begin
                        if (w_count_lt2) begin
                            w_set_err = 1'b1;
                        end else begin
                            w_pop   = 1'b1;
                            w_write = 1'b1;
                            w_value = (w_op == OP_ADD) ? (r_next + r_top) : (r_next - r_top);
                        end
                    end
                    OP_MUL: begin
`ifdef CALC_SEQ_MUL_EN
                        if (w_count_lt2) begin
                            w_set_err = 1'b1;
                        end else begin
                            w_mul_start = 1'b1;
                            w_state_nxt = MUL_RUN;
                        end
`else
                        w_set_err = 1'b1;
`endif
                    end
                    OP_CLEAR: begin
                        w_write   = 1'b1;
                        w_value   = {WIDTH{1'b0}};
                        w_clr_err = 1'b1;
                    end
                    OP_DROP: begin
                        if (w_count_zero) begin
                            w_set_err = 1'b1;
                        end else begin
                            w_pop = 1'b1;
                        end
                    end
                    default: w_set_err = 1'b1;
                endcase
            end
`ifdef CALC_SEQ_MUL_EN
            MUL_RUN: begin
                if (w_mul_done) begin
                    w_state_nxt = MUL_DONE;
                end else begin
                    w_state_nxt = MUL_RUN;
                end
            end
            MUL_DONE: begin
                w_pop       = 1'b1;
                w_write     = 1'b1;
                w_value     = w_mul_product;
                w_state_nxt = WAIT_RELEASE;
            end
`endif
            WAIT_RELEASE: begin
                if (!key[4]) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_RELEASE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, operand capture and registered outputs; error set has priority over clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_key   <= 5'b00000;
            r_top   <= {WIDTH{1'b0}};
            r_next  <= {WIDTH{1'b0}};
            r_count <= {COUNT_W{1'b0}};
            r_push  <= 1'b0;
            r_pop   <= 1'b0;
            r_write <= 1'b0;
            r_value <= {WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && key[4]) begin
                r_key   <= key;
                r_top   <= top;
                r_next  <= next;
                r_count <= count;
            end
            r_push  <= w_push;
            r_pop   <= w_pop;
            r_write <= w_write;
            r_value <= w_value;
            r_busy  <= (w_state_nxt == EXEC) || (w_state_nxt == MUL_RUN) || (w_state_nxt == MUL_DONE);
            if (stack_error || w_set_err) begin
                r_error <= 1'b1;
            end else if (w_clr_err) begin
                r_error <= 1'b0;
            end
        end
    end

    assign push  = r_push;
    assign pop   = r_pop;
    assign write = r_write;
    assign value = r_value;
    assign busy  = r_busy;
    assign error = r_error;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer; multiply checks follow CALC_SEQ_MUL_EN.
module tb_calc_sequencer;

    logic        clock;
    logic        reset_n;
    logic [4:0]  key;
    logic [31:0] top;
    logic [31:0] next;
    logic [5:0]  count;
    logic        stack_error;
    logic        push;
    logic        pop;
    logic        write;
    logic [31:0] value;
    logic        busy;
    logic        error;

    int checks   = 0;
    int failures = 0;

    int n_push = 0, n_pop = 0, n_write = 0, n_popwr = 0, n_busy = 0, n_bad = 0;
    logic [31:0] last_val = 32'd0;
    int b_push, b_pop, b_write, b_popwr, b_busy;

    calc_sequencer #(.WIDTH(32), .COUNT_W(6)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .key         (key),
        .top         (top),
        .next        (next),
        .count       (count),
        .stack_error (stack_error),
        .push        (push),
        .pop         (pop),
        .write       (write),
        .value       (value),
        .busy        (busy),
        .error       (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe monitor sampled away from the active edge.
    always @(negedge clock) begin
        if (push === 1'b1) n_push++;
        if (pop === 1'b1) n_pop++;
        if (write === 1'b1) n_write++;
        if ((pop === 1'b1) && (write === 1'b1)) n_popwr++;
        if (busy === 1'b1) n_busy++;
        if ((push === 1'b1) && (pop === 1'b1)) n_bad++;
        if ((push === 1'b1) || (write === 1'b1)) last_val = value;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic snap();
        b_push  = n_push;
        b_pop   = n_pop;
        b_write = n_write;
        b_popwr = n_popwr;
        b_busy  = n_busy;
    endtask

    task automatic press(input logic [4:0] k, input int hold);
        snap();
        key = k;
        step(hold);
        key = 5'b00000;
        step(6);
    endtask

    initial begin
        reset_n     = 1'b0;
        key         = 5'b00000;
        top         = 32'd0;
        next        = 32'd0;
        count       = 6'd0;
        stack_error = 1'b0;
        step(3);
        chk("rst_push", {63'd0, push}, 64'd0);
        chk("rst_pop", {63'd0, pop}, 64'd0);
        chk("rst_write", {63'd0, write}, 64'd0);
        chk("rst_value", {32'd0, value}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        reset_n = 1'b1;
        step(2);

        // digit 7 onto an empty stack pushes 7
        count = 6'd0; top = 32'd0;
        press(5'b10010, 2);
        chk("d7_push", 64'(n_push - b_push), 64'd1);
        chk("d7_wrpop", 64'((n_write - b_write) + (n_pop - b_pop)), 64'd0);
        chk("d7_value", {32'd0, last_val}, 64'd7);

        // digit 2 with top=7 writes 72
        count = 6'd1; top = 32'd7;
        press(5'b10100, 2);
        chk("d2_write", 64'(n_write - b_write), 64'd1);
        chk("d2_push", 64'(n_push - b_push), 64'd0);
        chk("d2_value", {32'd0, value}, 64'd72);

        // subtract 5-3 and 3-5
        count = 6'd2; next = 32'd5; top = 32'd3;
        press(5'b11110, 2);
        chk("sub_popwr", 64'(n_popwr - b_popwr), 64'd1);
        chk("sub_pop", 64'(n_pop - b_pop), 64'd1);
        chk("sub_value", {32'd0, last_val}, 64'd2);
        next = 32'd3; top = 32'd5;
        press(5'b11110, 2);
        chk("sub_neg", {32'd0, last_val}, 64'h0000_0000_FFFF_FFFE);

        // add 10+20
        next = 32'd10; top = 32'd20;
        press(5'b11101, 2);
        chk("add_popwr", 64'(n_popwr - b_popwr), 64'd1);
        chk("add_value", {32'd0, last_val}, 64'd30);

        // multiply 1234*567
        next = 32'd1234; top = 32'd567; count = 6'd2;
        press(5'b11111, 2);
        step(40);
`ifdef CALC_SEQ_MUL_EN
        chk("mul_busy", 64'(n_busy - b_busy), 64'd34);
        chk("mul_popwr", 64'(n_popwr - b_popwr), 64'd1);
        chk("mul_push", 64'(n_push - b_push), 64'd0);
        chk("mul_value", {32'd0, last_val}, 64'd699678);
        chk("mul_err", {63'd0, error}, 64'd0);
`else
        chk("mul_off_strb", 64'((n_push - b_push) + (n_pop - b_pop) + (n_write - b_write)), 64'd0);
        chk("mul_off_err", {63'd0, error}, 64'd1);
        press(5'b11011, 2);
        chk("mul_off_clr", {63'd0, error}, 64'd0);
`endif

        // add underflow, then clear
        count = 6'd1;
        press(5'b11101, 2);
        chk("uf_strb", 64'((n_push - b_push) + (n_pop - b_pop) + (n_write - b_write)), 64'd0);
        chk("uf_err", {63'd0, error}, 64'd1);
        press(5'b11011, 2);
        chk("clr_write", 64'(n_write - b_write), 64'd1);
        chk("clr_value", {32'd0, value}, 64'd0);
        chk("clr_err", {63'd0, error}, 64'd0);

        // drop on empty then on non-empty stack
        count = 6'd0;
        press(5'b10111, 2);
        chk("drop0_strb", 64'((n_push - b_push) + (n_pop - b_pop) + (n_write - b_write)), 64'd0);
        chk("drop0_err", {63'd0, error}, 64'd1);
        press(5'b11011, 2);
        count = 6'd3;
        press(5'b10111, 2);
        chk("drop_pop", 64'(n_pop - b_pop), 64'd1);
        chk("drop_wrpush", 64'((n_write - b_write) + (n_push - b_push)), 64'd0);
        chk("drop_err", {63'd0, error}, 64'd0);

        // enter
        press(5'b11100, 2);
        chk("ent_push", 64'(n_push - b_push), 64'd1);
        chk("ent_pop", 64'(n_pop - b_pop), 64'd0);

        // key 1 held for 50 cycles executes once
        count = 6'd1; top = 32'd5;
        press(5'b10000, 50);
        chk("hold_write", 64'(n_write - b_write), 64'd1);
        chk("hold_value", {32'd0, value}, 64'd51);

        // stack_error is sticky until key E
        stack_error = 1'b1;
        step(1);
        stack_error = 1'b0;
        step(3);
        chk("stk_err", {63'd0, error}, 64'd1);
        press(5'b11011, 2);
        chk("stk_clr", {63'd0, error}, 64'd0);

        // reset in the middle of a multiply
        next = 32'd1234; top = 32'd567; count = 6'd2;
        snap();
        key = 5'b11111;
        step(2);
        key = 5'b00000;
        step(10);
`ifdef CALC_SEQ_MUL_EN
        chk("abort_busy", {63'd0, busy}, 64'd1);
`else
        chk("abort_err", {63'd0, error}, 64'd1);
`endif
        reset_n = 1'b0;
        step(1);
        chk("abort_busy0", {63'd0, busy}, 64'd0);
        chk("abort_err0", {63'd0, error}, 64'd0);
        chk("abort_val0", {32'd0, value}, 64'd0);
        chk("abort_strb0", {61'd0, push, pop, write}, 64'd0);
        reset_n = 1'b1;
        step(40);
        chk("abort_strb", 64'((n_push - b_push) + (n_pop - b_pop) + (n_write - b_write)), 64'd0);
        chk("abort_idle", {63'd0, busy}, 64'd0);

        chk("push_pop_excl", 64'(n_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
